// File: rtl/signed_sat_accumulator.sv
// Frame accumulator for signed samples: sums N samples with saturation
// and holds one result, plus a sticky overflow flag, until the consumer takes it.
module signed_sat_accumulator #(
    parameter int WIDTH = 4,
    parameter int N     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_vld,
    input  logic [WIDTH-1:0] a,
    output logic             a_rdy,
    output logic             res_vld,
    output logic [WIDTH-1:0] res,
    output logic             res_ovf,
    input  logic             res_rdy
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] acc_n;
    logic [CW-1:0]    cnt;
    logic             ovf;
    logic             ov;
    logic             take;
    logic             last;
    logic             drain;

    assign a_rdy = (state == ACCUM);
    assign take  = a_vld & a_rdy;
    assign last  = (cnt == LAST);
    assign drain = res_vld & res_rdy;

    // Overflow only possible when both operands share a sign and the sum flips it
    always_comb begin
        sum   = acc + a;
        ov    = (acc[WIDTH-1] == a[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
        acc_n = sum;
        if (ov) begin
            acc_n = a[WIDTH-1] ? SMIN : SMAX;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ACCUM: if (take && last) state_n = HOLD;
            HOLD:  if (drain) state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            res_vld <= 1'b0;
            res     <= '0;
            res_ovf <= 1'b0;
        end else begin
            if (take) begin
                if (last) begin
                    acc     <= '0;
                    cnt     <= '0;
                    ovf     <= 1'b0;
                    res     <= acc_n;
                    res_ovf <= ovf | ov;
                    res_vld <= 1'b1;
                end else begin
                    acc <= acc_n;
                    cnt <= cnt + CW'(1);
                    ovf <= ovf | ov;
                end
            end else if (drain) begin
                res_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Directed bench for signed_sat_accumulator (WIDTH=4, N=4).
// Hand-computed frame sums, saturation, backpressure and reset cases.
module tb_signed_sat_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_vld;
    logic [3:0] a;
    logic       a_rdy;
    logic       res_vld;
    logic [3:0] res;
    logic       res_ovf;
    logic       res_rdy;

    int nvec  = 0;
    int nfail = 0;

    signed_sat_accumulator #(.WIDTH(4), .N(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_vld   (a_vld),
        .a       (a),
        .a_rdy   (a_rdy),
        .res_vld (res_vld),
        .res     (res),
        .res_ovf (res_ovf),
        .res_rdy (res_rdy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic feed(input string tag, input logic [3:0] v);
        chk1({tag, "_a_rdy"}, a_rdy, 1'b1);
        a_vld = 1'b1;
        a     = v;
        step();
    endtask

    task automatic frame(input string tag,
                         input logic [3:0] v0, input logic [3:0] v1,
                         input logic [3:0] v2, input logic [3:0] v3,
                         input logic [3:0] exp_res, input logic exp_ovf);
        feed(tag, v0);
        feed(tag, v1);
        feed(tag, v2);
        chk1({tag, "_vld_early"}, res_vld, 1'b0);
        feed(tag, v3);
        a_vld = 1'b0;
        chk1({tag, "_vld"}, res_vld, 1'b1);
        chk4({tag, "_res"}, res, exp_res);
        chk1({tag, "_ovf"}, res_ovf, exp_ovf);
        chk1({tag, "_hold_rdy"}, a_rdy, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        a_vld   = 1'b0;
        a       = 4'd0;
        res_rdy = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk1("rst_a_rdy", a_rdy, 1'b1);
        chk1("rst_vld", res_vld, 1'b0);
        chk4("rst_res", res, 4'd0);
        chk1("rst_ovf", res_ovf, 1'b0);

        // 1: plain sum, result for exactly one cycle with res_rdy=1
        frame("t1", 4'd1, 4'd2, -4'sd1, 4'd3, 4'd5, 1'b0);
        step();
        chk1("t1_vld_drop", res_vld, 1'b0);
        chk1("t1_a_rdy_back", a_rdy, 1'b1);
        chk4("t1_res_kept", res, 4'd5);

        // idle cycles change nothing
        step();
        step();
        chk1("idle_vld", res_vld, 1'b0);

        // 2: positive clamp then continue from 7
        frame("t2", 4'd4, 4'd4, -4'sd1, -4'sd1, 4'd5, 1'b1);
        step();

        // 3: negative clamp
        frame("t3", -4'sd8, -4'sd8, 4'd1, 4'd0, -4'sd7, 1'b1);
        step();

        // 4: backpressure with a sample waiting
        res_rdy = 1'b0;
        frame("t4", 4'd1, 4'd1, 4'd1, 4'd1, 4'd4, 1'b0);
        a_vld = 1'b1;
        a     = 4'd3;
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("t4_stall_rdy", a_rdy, 1'b0);
            chk1("t4_stall_vld", res_vld, 1'b1);
            chk4("t4_stall_res", res, 4'd4);
            chk1("t4_stall_ovf", res_ovf, 1'b0);
        end
        res_rdy = 1'b1;
        step();
        chk1("t4_rel_vld", res_vld, 1'b0);
        chk1("t4_rel_rdy", a_rdy, 1'b1);
        step();
        a_vld = 1'b0;
        feed("t4b", 4'd0);
        feed("t4b", 4'd0);
        feed("t4b", 4'd0);
        a_vld = 1'b0;
        chk1("t4b_vld", res_vld, 1'b1);
        chk4("t4b_res", res, 4'd3);
        chk1("t4b_ovf", res_ovf, 1'b0);
        step();

        // 5: reset mid-frame discards partial sum and sticky flag
        feed("t5", 4'd7);
        feed("t5", 4'd7);
        a_vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk4("t5_rst_res", res, 4'd0);
        chk1("t5_rst_vld", res_vld, 1'b0);
        chk1("t5_rst_rdy", a_rdy, 1'b1);
        #1;
        rst = 1'b0;
        step();
        frame("t5b", 4'd1, 4'd1, 4'd1, 4'd1, 4'd4, 1'b0);
        step();

        // reset while a result is held
        res_rdy = 1'b0;
        frame("t5c", 4'd2, 4'd2, 4'd0, 4'd0, 4'd4, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk1("t5c_rst_vld", res_vld, 1'b0);
        chk1("t5c_rst_rdy", a_rdy, 1'b1);
        rst = 1'b0;
        res_rdy = 1'b1;
        step();

        // 6: back-to-back frames
        frame("t6a", 4'd7, 4'd1, 4'd0, 4'd0, 4'd7, 1'b1);
        a_vld = 1'b1;
        a     = 4'd1;
        step();
        chk1("t6_gap_rdy", a_rdy, 1'b1);
        frame("t6b", 4'd1, 4'd1, 4'd1, 4'd1, 4'd4, 1'b0);
        step();
        chk1("t6_end_vld", res_vld, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
